// File: rtl/dot11_tx_pkg.sv
// Shared types and constants for the 802.11 transmit path.
package dot11_tx_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StPrefill,
    StStream,
    StDone
  } tx_state_e;

  localparam int unsigned DOT11_IQ_W = 16;

  typedef struct packed {
    logic signed [DOT11_IQ_W-1:0] i;
    logic signed [DOT11_IQ_W-1:0] q;
  } iq_sample_t;

  // 20 MSPS out of a 200 MHz clock
  localparam int unsigned DOT11_SAMPLE_DIV_20M = 10;

endpackage

// File: rtl/dot11_iq_sync_fifo.sv
// Single-clock show-ahead FIFO for packed I/Q samples; flush empties it in one cycle.
module dot11_iq_sync_fifo
  import dot11_tx_pkg::*;
#(
  parameter int unsigned WIDTH  = 2 * DOT11_IQ_W,
  parameter int unsigned ADDR_W = 9
) (
  input  logic              clk,
  input  logic              phy_tx_arestn,
  input  logic              flush,
  input  logic              push,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              pop,
  output logic [WIDTH-1:0]  rdata,
  output logic [ADDR_W:0]   level,
  output logic              full,
  output logic              empty
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W + 1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [ADDR_W:0]  wr_ptr_q, rd_ptr_q;
  logic             do_push, do_pop;

  assign level   = wr_ptr_q - rd_ptr_q;
  // Level never exceeds DEPTH, so its MSB alone marks full.
  assign full    = level[ADDR_W];
  assign empty   = (level == '0);
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;
  assign rdata   = mem[rd_ptr_q[ADDR_W-1:0]];

  always_ff @(posedge clk or negedge phy_tx_arestn) begin
    if (!phy_tx_arestn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q[ADDR_W-1:0]] <= wdata;
  end

endmodule

// File: rtl/dot11_tx_iq_pacer.sv
// Buffers bursty I/Q from dot11_tx and replays it to the DAC at one sample per SAMPLE_DIV clocks.
module dot11_tx_iq_pacer
  import dot11_tx_pkg::*;
#(
  parameter int unsigned DATA_W     = DOT11_IQ_W,
  parameter int unsigned ADDR_W     = 9,
  parameter int unsigned SAMPLE_DIV = DOT11_SAMPLE_DIV_20M,
  parameter int unsigned PREFILL    = 64
) (
  input  logic              clk,
  input  logic              phy_tx_arestn,
  input  logic              phy_tx_start,
  input  logic              src_done,
  input  logic              in_iq_valid,
  input  logic [DATA_W-1:0] in_i,
  input  logic [DATA_W-1:0] in_q,
  output logic              in_iq_ready,
  output logic              dac_iq_valid,
  output logic [DATA_W-1:0] dac_i,
  output logic [DATA_W-1:0] dac_q,
  output logic              dac_active,
  output logic              pkt_done,
  output logic              underrun,
  output logic [ADDR_W:0]   fifo_level
);

  localparam int unsigned     DIV_W       = $clog2(SAMPLE_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE    = DIV_W'(1);
  localparam logic [ADDR_W:0]  PREFILL_LVL = (ADDR_W + 1)'(PREFILL);

  tx_state_e          state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic               done_seen_q, done_seen_d;
  logic               underrun_q, underrun_d;
  logic               active_q, active_d;
  logic               valid_q;
  logic [DATA_W-1:0]  out_i_q, out_q_q;
  logic               emit, emit_pop, flush;
  logic [2*DATA_W-1:0] fifo_rdata;
  logic               fifo_full, fifo_empty;

  dot11_iq_sync_fifo #(
    .WIDTH  (2 * DATA_W),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk           (clk),
    .phy_tx_arestn (phy_tx_arestn),
    .flush         (flush),
    .push          (in_iq_valid & (state_q != StIdle)),
    .wdata         ({in_i, in_q}),
    .pop           (emit_pop),
    .rdata         (fifo_rdata),
    .level         (fifo_level),
    .full          (fifo_full),
    .empty         (fifo_empty)
  );

  assign in_iq_ready  = ~fifo_full;
  assign dac_iq_valid = valid_q;
  assign dac_i        = out_i_q;
  assign dac_q        = out_q_q;
  assign dac_active   = active_q;
  assign pkt_done     = (state_q == StDone);
  assign underrun     = underrun_q;

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    done_seen_d = done_seen_q | src_done;
    underrun_d  = underrun_q;
    active_d    = active_q;
    emit        = 1'b0;
    emit_pop    = 1'b0;
    flush       = 1'b0;
    unique case (state_q)
      StIdle: done_seen_d = 1'b0;
      StPrefill: begin
        if ((fifo_level >= PREFILL_LVL) || (done_seen_q && !fifo_empty)) begin
          state_d = StStream;
          div_d   = '0;
        end else if (done_seen_q) begin
          state_d = StDone;
        end
      end
      StStream: begin
        div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_ONE;
        if (div_q == '0) begin
          if (!fifo_empty) begin
            emit     = 1'b1;
            emit_pop = 1'b1;
            active_d = 1'b1;
          end else if (!done_seen_q) begin
            // Keep the DAC cadence with a zero sample rather than re-prefilling.
            emit       = 1'b1;
            underrun_d = 1'b1;
            active_d   = 1'b1;
          end else begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        state_d  = StIdle;
        active_d = 1'b0;
      end
      default: state_d = StIdle;
    endcase
    if (phy_tx_start) begin
      state_d     = StPrefill;
      div_d       = '0;
      done_seen_d = 1'b0;
      underrun_d  = 1'b0;
      active_d    = 1'b0;
      emit        = 1'b0;
      emit_pop    = 1'b0;
      flush       = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge phy_tx_arestn) begin
    if (!phy_tx_arestn) begin
      state_q     <= StIdle;
      div_q       <= '0;
      done_seen_q <= 1'b0;
      underrun_q  <= 1'b0;
      active_q    <= 1'b0;
      valid_q     <= 1'b0;
      out_i_q     <= '0;
      out_q_q     <= '0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      done_seen_q <= done_seen_d;
      underrun_q  <= underrun_d;
      active_q    <= active_d;
      valid_q     <= emit;
      out_i_q     <= emit_pop ? fifo_rdata[2*DATA_W-1:DATA_W] : '0;
      out_q_q     <= emit_pop ? fifo_rdata[DATA_W-1:0] : '0;
    end
  end

endmodule

// File: tb/tb_dot11_tx_iq_pacer.sv
// Directed bench for dot11_tx_iq_pacer with a queue-based reference model checked every cycle.
module tb_dot11_tx_iq_pacer;
  import dot11_tx_pkg::*;

  localparam int unsigned DEPTH   = 512;
  localparam int unsigned PREFILL = 64;
  localparam int unsigned DIV     = 10;

  logic        clk = 1'b0;
  logic        phy_tx_arestn = 1'b1;
  logic        phy_tx_start = 1'b0, src_done = 1'b0, in_iq_valid = 1'b0;
  logic [15:0] in_i = '0, in_q = '0;
  logic        in_iq_ready, dac_iq_valid, dac_active, pkt_done, underrun;
  logic [15:0] dac_i, dac_q;
  logic [9:0]  fifo_level;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dot11_tx_iq_pacer #(
    .DATA_W     (16),
    .ADDR_W     (9),
    .SAMPLE_DIV (DIV),
    .PREFILL    (PREFILL)
  ) dut (
    .clk           (clk),
    .phy_tx_arestn (phy_tx_arestn),
    .phy_tx_start  (phy_tx_start),
    .src_done      (src_done),
    .in_iq_valid   (in_iq_valid),
    .in_i          (in_i),
    .in_q          (in_q),
    .in_iq_ready   (in_iq_ready),
    .dac_iq_valid  (dac_iq_valid),
    .dac_i         (dac_i),
    .dac_q         (dac_q),
    .dac_active    (dac_active),
    .pkt_done      (pkt_done),
    .underrun      (underrun),
    .fifo_level    (fifo_level)
  );

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: mode 0 idle, 1 prefill, 2 stream, 3 done; strobes scheduled by cycle number.
  int          m_mode;
  logic [31:0] m_fifo[$];
  longint      cyc, m_next_tick;
  bit          m_done_seen, m_underrun, m_active, e_valid;
  logic [15:0] e_i, e_q;

  task automatic m_reset();
    m_fifo.delete();
    m_mode = 0; m_done_seen = 0; m_underrun = 0; m_active = 0;
    e_valid = 0; e_i = '0; e_q = '0; m_next_tick = 0;
  endtask

  task automatic m_step();
    int lvl;
    bit ready, push_ok, old_done;
    logic [31:0] head;
    cyc++;
    lvl   = m_fifo.size();
    ready = (lvl != DEPTH);
    e_valid = 0; e_i = '0; e_q = '0;
    if (phy_tx_start) begin
      m_fifo.delete();
      m_mode = 1; m_done_seen = 0; m_underrun = 0; m_active = 0;
    end else begin
      push_ok  = in_iq_valid && ready && (m_mode != 0);
      old_done = m_done_seen;
      m_done_seen = (m_mode == 0) ? 1'b0 : (m_done_seen | src_done);
      case (m_mode)
        1: begin
          if (lvl >= PREFILL || (old_done && lvl > 0)) begin
            m_mode = 2; m_next_tick = cyc + 1;
          end else if (old_done) m_mode = 3;
        end
        2: begin
          if (cyc == m_next_tick) begin
            m_next_tick = cyc + DIV;
            if (lvl > 0) begin
              head = m_fifo.pop_front();
              e_valid = 1; e_i = head[31:16]; e_q = head[15:0]; m_active = 1;
            end else if (!old_done) begin
              e_valid = 1; m_underrun = 1; m_active = 1;
            end else m_mode = 3;
          end
        end
        3: begin m_mode = 0; m_active = 0; end
        default: ;
      endcase
      if (push_ok) m_fifo.push_back({in_i, in_q});
    end
  endtask

  initial begin
    cyc = 0;
    m_reset();
    forever begin
      @(posedge clk or negedge phy_tx_arestn);
      if (!phy_tx_arestn) m_reset();
      else m_step();
    end
  end

  // Observation statistics used by the directed literal checks.
  int          n_strobe, n_zero, n_pkt, min_gap, max_gap, max_level;
  bit          active_seen, ready_low;
  longint      ncyc = 0, last_strobe_cyc, done_gap;
  logic [15:0] first_i, last_i;

  task automatic clear_stats();
    n_strobe = 0; n_zero = 0; n_pkt = 0; min_gap = 1000000; max_gap = 0; max_level = 0;
    active_seen = 0; ready_low = 0; last_strobe_cyc = -1; done_gap = -1;
    first_i = '0; last_i = '0;
  endtask

  initial begin
    clear_stats();
    forever begin
      @(negedge clk);
      check("dac_iq_valid", dac_iq_valid, e_valid);
      check("dac_i", dac_i, e_i);
      check("dac_q", dac_q, e_q);
      check("dac_active", dac_active, m_active);
      check("pkt_done", pkt_done, m_mode == 3);
      check("underrun", underrun, m_underrun);
      check("fifo_level", fifo_level, m_fifo.size());
      check("in_iq_ready", in_iq_ready, m_fifo.size() != DEPTH);
      if (dac_iq_valid) begin
        n_strobe++;
        if (n_strobe == 1) first_i = dac_i;
        if (dac_i == 0 && dac_q == 0) n_zero++;
        last_i = dac_i;
        if (last_strobe_cyc >= 0) begin
          if (int'(ncyc - last_strobe_cyc) < min_gap) min_gap = int'(ncyc - last_strobe_cyc);
          if (int'(ncyc - last_strobe_cyc) > max_gap) max_gap = int'(ncyc - last_strobe_cyc);
        end
        last_strobe_cyc = ncyc;
      end
      if (pkt_done) begin n_pkt++; done_gap = ncyc - last_strobe_cyc; end
      if (dac_active) active_seen = 1;
      if (!in_iq_ready) ready_low = 1;
      if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
      ncyc++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_pkt();
    phy_tx_start = 1'b1; step(); phy_tx_start = 1'b0;
  endtask

  task automatic pulse_done();
    src_done = 1'b1; step(); src_done = 1'b0;
  endtask

  task automatic push_seq(input int n, input int base);
    for (int k = 1; k <= n; k++) begin
      int waited;
      bit acc;
      waited = 0;
      in_iq_valid = 1'b1;
      in_i = 16'(base + k);
      in_q = 16'(-(base + k));
      do begin
        @(negedge clk);
        acc = in_iq_ready;
        step();
        waited++;
      end while (!acc && waited < 5000);
      if (!acc) begin
        checks++; errors++;
        $display("FAIL push_timeout: got no ready, expected ready within 5000 cycles");
      end
    end
    in_iq_valid = 1'b0;
  endtask

  task automatic wait_pkt(input int bound, output int took);
    took = -1;
    for (int c = 0; c < bound; c++) begin
      @(negedge clk);
      if (pkt_done) begin took = c; break; end
    end
    if (took < 0) begin
      checks++; errors++;
      $display("FAIL pkt_done_timeout: got none, expected within %0d cycles", bound);
    end
    step();
  endtask

  initial begin
    #400000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int took;
    #1 phy_tx_arestn = 1'b0;
    repeat (3) step();
    phy_tx_arestn = 1'b1;
    step();
    check("rst_ready", in_iq_ready, 1);
    check("rst_level", fifo_level, 0);
    check("rst_valid", dac_iq_valid, 0);
    check("rst_model_level", m_fifo.size(), 0);

    // 1: nominal 200-sample packet
    clear_stats();
    start_pkt();
    push_seq(200, 0);
    pulse_done();
    wait_pkt(3000, took);
    check("t1_strobes", n_strobe, 200);
    check("t1_min_gap", min_gap, 10);
    check("t1_max_gap", max_gap, 10);
    check("t1_first_i", first_i, 1);
    check("t1_last_i", last_i, 200);
    check("t1_underrun", underrun, 0);
    check("t1_pkts", n_pkt, 1);
    check("t1_done_gap", done_gap, 10);

    // 2: overfill to exercise backpressure
    clear_stats();
    start_pkt();
    push_seq(600, 0);
    pulse_done();
    wait_pkt(8000, took);
    check("t2_strobes", n_strobe, 600);
    check("t2_last_i", last_i, 600);
    check("t2_max_level", max_level, 512);
    check("t2_ready_low", ready_low, 1);
    check("t2_max_gap", max_gap, 10);
    check("t2_underrun", underrun, 0);

    // 3: source stall causes zero-valued strobes
    clear_stats();
    start_pkt();
    push_seq(64, 0);
    repeat (2000) step();
    check("t3_underrun", underrun, 1);
    check("t3_strobes_gap", n_strobe, 200);
    check("t3_zero_strobes", n_zero, 136);
    push_seq(10, 1000);
    pulse_done();
    wait_pkt(500, took);
    check("t3_underrun_held", underrun, 1);
    check("t3_last_i", last_i, 1010);
    check("t3_pkts", n_pkt, 1);
    start_pkt();
    check("t3_underrun_cleared", underrun, 0);

    // 4: empty packet
    clear_stats();
    start_pkt();
    pulse_done();
    wait_pkt(10, took);
    check("t4_fast_done", took < 3, 1);
    check("t4_strobes", n_strobe, 0);
    check("t4_active_seen", active_seen, 0);

    // 5: restart mid-stream
    clear_stats();
    start_pkt();
    push_seq(120, 0);
    check("t5_level_before", fifo_level, 114);
    start_pkt();
    check("t5_level_flushed", fifo_level, 0);
    check("t5_active_dropped", dac_active, 0);
    check("t5_no_pkt_done", n_pkt, 0);
    clear_stats();
    push_seq(80, 2000);
    pulse_done();
    wait_pkt(1500, took);
    check("t5_strobes", n_strobe, 80);
    check("t5_first_i", first_i, 2001);
    check("t5_last_i", last_i, 2080);
    check("t5_pkts", n_pkt, 1);

    // 6: asynchronous reset mid-stream
    clear_stats();
    start_pkt();
    push_seq(100, 3000);
    repeat (30) step();
    check("t6_active_before", dac_active, 1);
    #2 phy_tx_arestn = 1'b0;
    #1;
    check("t6_rst_valid", dac_iq_valid, 0);
    check("t6_rst_i", dac_i, 0);
    check("t6_rst_active", dac_active, 0);
    check("t6_rst_level", fifo_level, 0);
    check("t6_rst_ready", in_iq_ready, 1);
    repeat (3) step();
    phy_tx_arestn = 1'b1;
    clear_stats();
    repeat (50) step();
    check("t6_no_strobe", n_strobe, 0);
    check("t6_level_after", fifo_level, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
